e203_ifu_dynbpu: RTL and testbench

Next-generation IFU branch prediction unit. It replaces purely static Bxx prediction with a parametrised branch history table (BHT) of 2-bit saturating counters, which EXU trains on branch resolution. It adds a parametrised return address stack (RAS) for call/return prediction, and an explicit FSM for the JALR-xN dependency wait and regfile read. It sits between the IFU mini-decoder and PC generation, and produces the next-PC adder operands.

---
 rtl/e203_ifu_dynbpu.sv | 187 ++++++++++++++++++
 tb/tb_e203_ifu_dynbpu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_ifu_dynbpu.sv
// IFU dynamic branch predictor: 2-bit BHT for Bxx, circular RAS for call/return, JALR-xN regfile-read FSM.
// Prediction and adder operands are combinational; bpu_wait holds the IFU while a JALR base is not yet readable.
module e203_ifu_dynbpu #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int BHT_DEPTH   = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic                   dec_i_valid,
  input  logic                   dec_i_accept,
  input  logic                   dec_rv32,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [XLEN-1:0]        dec_bjp_imm,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
  input  logic                   ir_empty,
  input  logic                   ir_rs1en,
  input  logic                   ir_valid_clr,
  input  logic                   jalr_rs1idx_cam_irrdidx,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  input  logic                   upd_valid,
  input  logic [PC_SIZE-1:0]     upd_pc,
  input  logic                   upd_taken,
  output logic                   bpu_wait,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
  output logic                   bpu2rf_rs1_ena
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DEP, RDRF} state_t;

  // ---------------- BHT ----------------
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_upd_pc;

  assign lkp_idx       = pc[IDX_W:1];
  assign upd_idx       = upd_pc[IDX_W:1];
  assign unused_upd_pc = ^upd_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_taken && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'b01;
      else if (!upd_taken && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'b01;
    end
  end

  // ---------------- instruction classification ----------------
  logic rs1_x0, rs1_x1, rs1_link, rd_link;
  logic is_call, is_ret, is_coro, jalr_only;
  logic ras_empty, sel_ras, sel_x0, sel_x1, sel_xn;

  assign rs1_x0    = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
  assign rs1_x1    = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
  assign rs1_link  = rs1_x1 | (dec_jalr_rs1idx == RFIDX_WIDTH'(5));
  assign rd_link   = (dec_rdidx == RFIDX_WIDTH'(1)) | (dec_rdidx == RFIDX_WIDTH'(5));
  assign is_call   = (dec_jal | (dec_jalr & ~rs1_link)) & rd_link;
  assign is_ret    = dec_jalr & rs1_link & ~rd_link;
  assign is_coro   = dec_jalr & rs1_link & rd_link;
  assign jalr_only = dec_jalr & ~dec_bxx & ~dec_jal;
  assign sel_ras   = jalr_only & is_ret & ~ras_empty;
  assign sel_x0    = jalr_only & ~sel_ras & rs1_x0;
  assign sel_x1    = jalr_only & ~sel_ras & rs1_x1;
  assign sel_xn    = jalr_only & ~sel_ras & ~rs1_x0 & ~rs1_x1;

  // ---------------- JALR-xN FSM ----------------
  state_t state, state_nxt;
  logic   dep, jalr_xn, x1_wait, xn_wait, rdrf_set;

  assign dep     = ~ir_empty & ir_rs1en & ~ir_valid_clr;
  assign jalr_xn = dec_i_valid & sel_xn;
  assign x1_wait = dec_i_valid & sel_x1 & jalr_rs1idx_cam_irrdidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Wait is also raised on the IDLE->WAIT_DEP cycle so the jalr cannot slip through with a stale base.
  always_comb begin
    state_nxt = state;
    rdrf_set  = 1'b0;
    xn_wait   = 1'b0;
    case (state)
      IDLE: begin
        if (jalr_xn) begin
          xn_wait = 1'b1;
          if (dep) begin
            state_nxt = WAIT_DEP;
          end else begin
            state_nxt = RDRF;
            rdrf_set  = 1'b1;
          end
        end
      end
      WAIT_DEP: begin
        xn_wait = 1'b1;
        if (!dec_i_valid) begin
          state_nxt = IDLE;
        end else if (!dep) begin
          state_nxt = RDRF;
          rdrf_set  = 1'b1;
        end
      end
      RDRF:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bpu_wait       = xn_wait | x1_wait;
  assign bpu2rf_rs1_ena = rdrf_set;

  // ---------------- RAS ----------------
  logic [PC_SIZE-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]   wp, wp_inc, wp_dec;
  logic [CNT_W-1:0]   cnt;
  logic [PC_SIZE-1:0] link_pc, ras_top;
  logic               commit, push, pop, repl;

  assign ras_empty = (cnt == CNT_W'(0));
  assign wp_inc    = (wp == PTR_W'(RAS_DEPTH - 1)) ? PTR_W'(0) : wp + PTR_W'(1);
  assign wp_dec    = (wp == PTR_W'(0)) ? PTR_W'(RAS_DEPTH - 1) : wp - PTR_W'(1);
  assign ras_top   = ras_mem[wp_dec];
  assign link_pc   = pc + (dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
  assign commit    = dec_i_valid & dec_i_accept & ~bpu_wait;
  assign push      = commit & (is_call | (is_coro & ras_empty));
  assign pop       = commit & is_ret & ~ras_empty;
  assign repl      = commit & is_coro & ~ras_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp <= wp_inc;
      if (cnt != CNT_W'(RAS_DEPTH)) cnt <= cnt + CNT_W'(1);
    end else if (pop) begin
      wp  <= wp_dec;
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)      ras_mem[wp]     <= link_pc;
    else if (repl) ras_mem[wp_dec] <= link_pc;
  end

  // ---------------- prediction and adder operands ----------------
  assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bht[lkp_idx][1]);

  always_comb begin
    prdt_pc_add_op1 = '0;
    prdt_pc_add_op2 = '0;
    if (dec_bxx | dec_jal) begin
      prdt_pc_add_op1 = pc;
      prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
    end else if (sel_ras) begin
      prdt_pc_add_op1 = ras_top;
    end else if (sel_x0) begin
      prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
    end else if (sel_x1) begin
      prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
      prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
    end else if (sel_xn) begin
      prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
      prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
    end
  end

endmodule

// File: tb/tb_e203_ifu_dynbpu.sv
// Directed bench for e203_ifu_dynbpu: BHT training/saturation, RAS call/return, JALR-xN FSM, reset mid-operation.
module tb_e203_ifu_dynbpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        dec_i_valid, dec_i_accept, dec_rv32, dec_jal, dec_jalr, dec_bxx;
  logic [31:0] dec_bjp_imm;
  logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
  logic        ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
  logic [31:0] rf2bpu_x1, rf2bpu_rs1;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        bpu_wait, prdt_taken, bpu2rf_rs1_ena;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_ifu_dynbpu dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .dec_i_valid(dec_i_valid), .dec_i_accept(dec_i_accept), .dec_rv32(dec_rv32),
    .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx),
    .ir_empty(ir_empty), .ir_rs1en(ir_rs1en), .ir_valid_clr(ir_valid_clr),
    .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx),
    .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .bpu_wait(bpu_wait), .prdt_taken(prdt_taken),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
    .bpu2rf_rs1_ena(bpu2rf_rs1_ena)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    pc = '0; dec_i_valid = 0; dec_i_accept = 0; dec_rv32 = 1; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_bjp_imm = '0; dec_jalr_rs1idx = '0; dec_rdidx = '0;
    ir_empty = 1; ir_rs1en = 0; ir_valid_clr = 0; jalr_rs1idx_cam_irrdidx = 0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0;
  endtask

  task automatic do_upd(input logic [31:0] a, input logic t, input int n);
    for (int i = 0; i < n; i++) begin
      upd_valid = 1; upd_pc = a; upd_taken = t;
      tick();
    end
    upd_valid = 0;
  endtask

  task automatic bxx_at(input logic [31:0] a, input logic [31:0] imm);
    clr();
    dec_i_valid = 1; dec_bxx = 1; pc = a; dec_bjp_imm = imm;
    #1;
  endtask

  task automatic call_at(input logic [31:0] a, input logic rv32);
    clr();
    dec_i_valid = 1; dec_i_accept = 1; dec_jal = 1; dec_rdidx = 5'd1; pc = a; dec_rv32 = rv32;
    dec_bjp_imm = 32'h40;
    tick();
    clr();
  endtask

  task automatic ret_set(input logic [31:0] imm);
    clr();
    dec_i_valid = 1; dec_i_accept = 1; dec_jalr = 1; dec_jalr_rs1idx = 5'd1; dec_rdidx = 5'd0;
    pc = 32'h0000_0f00; dec_bjp_imm = imm;
    #1;
  endtask

  task automatic jalr_x7(input logic with_dep);
    clr();
    dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 5'd7; dec_rdidx = 5'd0; dec_bjp_imm = 32'h10;
    pc = 32'h0000_0500; ir_empty = ~with_dep; ir_rs1en = 1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp;
    clr();
    rf2bpu_x1 = 32'h0005_a5a0; rf2bpu_rs1 = 32'h0000_4000;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_taken", 32'(prdt_taken), 0);
    chk("rst_op1", prdt_pc_add_op1, 0);
    chk("rst_op2", prdt_pc_add_op2, 0);
    chk("rst_wait", 32'(bpu_wait), 0);
    chk("rst_ena", 32'(bpu2rf_rs1_ena), 0);
    rst_n = 1;
    tick();

    // BHT training
    bxx_at(32'h100, 32'h20);
    chk("bxx_init_nt", 32'(prdt_taken), 0);
    do_upd(32'h100, 1, 3);
    bxx_at(32'h100, 32'h20);
    chk("bxx_trained_t", 32'(prdt_taken), 1);
    chk("bxx_op1", prdt_pc_add_op1, 32'h100);
    chk("bxx_op2", prdt_pc_add_op2, 32'h20);

    // Saturation at a different index
    do_upd(32'h104, 1, 5);
    do_upd(32'h104, 0, 1);
    bxx_at(32'h104, 32'h4);
    chk("sat_one_nt", 32'(prdt_taken), 1);
    do_upd(32'h104, 0, 1);
    bxx_at(32'h104, 32'h4);
    chk("sat_two_nt", 32'(prdt_taken), 0);
    upd_valid = 1; upd_pc = 32'h104; upd_taken = 1;
    #1;
    chk("same_cyc_old", 32'(prdt_taken), 0);
    tick();
    upd_valid = 0;
    #1;
    chk("same_cyc_after", 32'(prdt_taken), 1);

    // RAS basic call/return
    call_at(32'h200, 1);
    ret_set(32'h0);
    chk("ret32_op1", prdt_pc_add_op1, 32'h204);
    chk("ret32_op2", prdt_pc_add_op2, 0);
    chk("ret32_wait", 32'(bpu_wait), 0);
    tick();
    call_at(32'h300, 0);
    ret_set(32'h0);
    chk("ret16_op1", prdt_pc_add_op1, 32'h302);
    tick();

    // Empty RAS falls back to x1, with x1 dependency wait
    ret_set(32'h8);
    dec_i_accept = 0; jalr_rs1idx_cam_irrdidx = 1;
    #1;
    chk("x1_op1", prdt_pc_add_op1, 32'h0005_a5a0);
    chk("x1_op2", prdt_pc_add_op2, 32'h8);
    chk("x1_dep_wait", 32'(bpu_wait), 1);
    jalr_rs1idx_cam_irrdidx = 0;
    #1;
    chk("x1_nodep_wait", 32'(bpu_wait), 0);
    clr();

    // Overflow: 5 calls into a 4-deep RAS, then 5 returns
    for (int i = 0; i < 5; i++) call_at(32'h1000 + 32'(i) * 32'h100, 1);
    for (int i = 0; i < 5; i++) begin
      ret_set(32'h8);
      exp = (i < 4) ? (32'h1000 + 32'(4 - i) * 32'h100 + 32'h4) : 32'h0005_a5a0;
      chk($sformatf("ovf_ret%0d_op1", i), prdt_pc_add_op1, exp);
      chk($sformatf("ovf_ret%0d_op2", i), prdt_pc_add_op2, (i < 4) ? 32'h0 : 32'h8);
      tick();
    end
    clr();

    // JALR-xN with IR dependency
    jalr_x7(1);
    chk("xn_dep_wait0", 32'(bpu_wait), 1);
    chk("xn_dep_ena0", 32'(bpu2rf_rs1_ena), 0);
    tick();
    chk("xn_wdep_wait", 32'(bpu_wait), 1);
    chk("xn_wdep_ena", 32'(bpu2rf_rs1_ena), 0);
    tick();
    chk("xn_wdep_wait2", 32'(bpu_wait), 1);
    ir_empty = 1;
    #1;
    chk("xn_clr_wait", 32'(bpu_wait), 1);
    chk("xn_clr_ena", 32'(bpu2rf_rs1_ena), 1);
    tick();
    chk("xn_rdrf_op1", prdt_pc_add_op1, 32'h4000);
    chk("xn_rdrf_op2", prdt_pc_add_op2, 32'h10);
    chk("xn_rdrf_wait", 32'(bpu_wait), 0);
    chk("xn_rdrf_ena", 32'(bpu2rf_rs1_ena), 0);
    dec_i_accept = 1;
    tick();
    clr();

    // JALR-xN without dependency
    jalr_x7(0);
    chk("xn_nodep_wait", 32'(bpu_wait), 1);
    chk("xn_nodep_ena", 32'(bpu2rf_rs1_ena), 1);
    tick();
    chk("xn_nodep_rdrf_wait", 32'(bpu_wait), 0);
    tick();
    clr();

    // Flush out of WAIT_DEP
    jalr_x7(1);
    tick();
    dec_i_valid = 0;
    #1;
    chk("flush_wdep_wait", 32'(bpu_wait), 1);
    tick();
    chk("flush_idle_wait", 32'(bpu_wait), 0);
    clr();
    tick();

    // Reset while in WAIT_DEP with 3 RAS entries and trained BHT
    for (int i = 0; i < 3; i++) call_at(32'h2000 + 32'(i) * 32'h100, 1);
    jalr_x7(1);
    tick();
    rst_n = 0;
    dec_i_valid = 0;
    #1;
    chk("arst_fsm_idle", 32'(bpu_wait), 0);
    #3;
    rst_n = 1;
    tick();
    ret_set(32'h0);
    chk("arst_ras_empty", prdt_pc_add_op1, 32'h0005_a5a0);
    bxx_at(32'h100, 32'h20);
    chk("arst_bht_nt", 32'(prdt_taken), 0);
    do_upd(32'h100, 1, 1);
    bxx_at(32'h100, 32'h20);
    chk("arst_bht_01", 32'(prdt_taken), 1);
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
